// File: rtl/udp_axis_echo_responder_pkg.sv
// Shared types and constants for the UDP/CMAC echo responder.
// Holds the default-width AXIS beat, Ethernet header offsets and the echo FSM states.
package udp_axis_echo_responder_pkg;

  localparam int AXIS_DATA_WIDTH = 512;
  localparam int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8;
  localparam int AXIS_USER_WIDTH = 1;

  localparam int MAC_ADDR_BYTES = 6;
  localparam int ETH_DST_OFFSET = 0;
  localparam int ETH_SRC_OFFSET = 6;

  // Widest tkeep the contiguity check accepts (DATA_WIDTH up to 2048).
  localparam int MAX_KEEP_WIDTH = 256;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] data;
    logic [AXIS_KEEP_WIDTH-1:0] keep;
    logic                       last;
    logic [AXIS_USER_WIDTH-1:0] user;
  } axis_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FWD     = 2'd1,
    ST_DISCARD = 2'd2
  } echo_state_t;

  // True when keep is 2^n-1 with n >= 1; zero-extension preserves the property.
  function automatic logic keep_is_contiguous(input logic [MAX_KEEP_WIDTH-1:0] keep);
    return (keep != '0) && (((keep + MAX_KEEP_WIDTH'(1)) & keep) == '0);
  endfunction

endpackage

// File: rtl/udp_axis_echo_responder_skid_buffer.sv
// Two-entry AXIS register slice: one output register plus one skid register.
// Full throughput with a registered ready; reusable for cross-die pipelining.
module axis_skid_buffer #(
  parameter int WIDTH = 578
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             load_out;

  assign in_ready = !skid_valid;
  assign load_out = out_ready || !out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
    end else if (load_out) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && in_ready) begin
      skid_valid <= 1'b1;
    end
  end

  // NOTE: skid_data is qualified by skid_valid, so it needs no reset; only
  // the visible output register is cleared.
  always_ff @(posedge clk) begin
    if (!load_out && in_valid && in_ready) skid_data <= in_data;
  end

endmodule

// File: rtl/udp_axis_echo_responder.sv
// Far-end echo responder: reflects RX frames to TX with a first-beat MAC swap,
// frame-granular enable/discard, tkeep sanity checking and frame statistics.
module udp_axis_echo_responder
  import udp_axis_echo_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  udp_clk,
  input  logic                  udp_reset,
  input  logic                  echo_enable,
  input  logic                  clear_cnt,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic [CNT_WIDTH-1:0]  echo_frame_cnt,
  output logic [CNT_WIDTH-1:0]  drop_frame_cnt,
  output logic [CNT_WIDTH-1:0]  err_frame_cnt,
  output logic                  busy
);

  localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;

  echo_state_t           state;
  logic                  frame_err;
  logic                  skid_ready;
  logic                  accept;
  logic                  echo_beat;
  logic                  beat_err;
  logic [DATA_WIDTH-1:0] swapped;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [BEAT_W-1:0]     buf_out;

  // DISCARD never stores anything, so it can always sink beats.
  assign s_axis_tready = (state == ST_DISCARD) || skid_ready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign echo_beat     = (state == ST_FWD) || ((state == ST_IDLE) && echo_enable);
  assign beat_err      = s_axis_tlast ? !keep_is_contiguous(MAX_KEEP_WIDTH'(s_axis_tkeep))
                                      : (s_axis_tkeep != '1);

  // NOTE: default the whole vector before the byte overrides so every bit is
  // assigned on every pass and no latch is inferred.
  always_comb begin
    swapped = s_axis_tdata;
    for (int i = 0; i < MAC_ADDR_BYTES; i++) begin
      swapped[8*(ETH_DST_OFFSET+i) +: 8] = s_axis_tdata[8*(ETH_SRC_OFFSET+i) +: 8];
      swapped[8*(ETH_SRC_OFFSET+i) +: 8] = s_axis_tdata[8*(ETH_DST_OFFSET+i) +: 8];
    end
  end

  assign fwd_data = (state == ST_IDLE) ? swapped : s_axis_tdata;

  axis_skid_buffer #(.WIDTH(BEAT_W)) u_skid (
    .clk       (udp_clk),
    .rst       (udp_reset),
    .in_valid  (accept && echo_beat),
    .in_ready  (skid_ready),
    .in_data   ({fwd_data, s_axis_tkeep, s_axis_tlast, s_axis_tuser}),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .out_data  (buf_out)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = buf_out;
  assign busy = (state != ST_IDLE) || m_axis_tvalid || !skid_ready;

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge udp_clk or posedge udp_reset) begin
    if (udp_reset) begin
      state          <= ST_IDLE;
      frame_err      <= 1'b0;
      echo_frame_cnt <= '0;
      drop_frame_cnt <= '0;
      err_frame_cnt  <= '0;
    end else begin
      if (accept) begin
        frame_err <= s_axis_tlast ? 1'b0 : (frame_err || beat_err);
        case (state)
          ST_IDLE:    if (!s_axis_tlast) state <= echo_enable ? ST_FWD : ST_DISCARD;
          ST_FWD,
          ST_DISCARD: if (s_axis_tlast) state <= ST_IDLE;
          default:    state <= ST_IDLE;
        endcase
      end
      // Clear wins over a coincident frame-end increment.
      if (clear_cnt) begin
        echo_frame_cnt <= '0;
        drop_frame_cnt <= '0;
        err_frame_cnt  <= '0;
      end else if (accept && s_axis_tlast) begin
        if (echo_beat) echo_frame_cnt <= echo_frame_cnt + CNT_WIDTH'(1);
        else           drop_frame_cnt <= drop_frame_cnt + CNT_WIDTH'(1);
        if (frame_err || beat_err) err_frame_cnt <= err_frame_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: doc/udp_axis_echo_responder.md
Name: udp_axis_echo_responder

Overview:
- Far-end responder for the UDP/CMAC performance-monitor traffic.
- Accepts 512-bit AXI-Stream Ethernet frames arriving from the CMAC RX path and reflects them back onto the TX path.
- Swaps the destination and source MAC addresses in the first beat, so the initiator's monitor receives its own frames back.
- Provides frame-granular enable/discard, tkeep sanity checking and echo/drop/error statistics for ILA probing.

Parameters:
- DATA_WIDTH, 512: AXIS tdata width in bits. Must be a multiple of 8 and at least 96.
- KEEP_WIDTH, 64: tkeep width. Equals DATA_WIDTH/8.
- USER_WIDTH, 1: tuser width. Passed through unchanged.
- CNT_WIDTH, 32: width of each statistics counter.

Ports:
- udp_clk  in  1  sole clock; all logic on the rising edge.
- udp_reset  in  1  asynchronous, active-high reset.
- echo_enable  in  1  when 1, echo frames; when 0, discard frames. Sampled only at frame start.
- clear_cnt  in  1  synchronous clear of all statistics counters.
- s_axis_tvalid  in  1  RX stream valid.
- s_axis_tready  out  1  RX stream ready.
- s_axis_tdata  in  DATA_WIDTH  RX data; byte 0 = tdata[7:0].
- s_axis_tkeep  in  KEEP_WIDTH  RX byte enables.
- s_axis_tlast  in  1  RX end of frame.
- s_axis_tuser  in  USER_WIDTH  RX sideband.
- m_axis_tvalid  out  1  TX stream valid.
- m_axis_tready  in  1  TX stream ready.
- m_axis_tdata  out  DATA_WIDTH  TX data.
- m_axis_tkeep  out  KEEP_WIDTH  TX byte enables.
- m_axis_tlast  out  1  TX end of frame.
- m_axis_tuser  out  USER_WIDTH  TX sideband.
- echo_frame_cnt  out  CNT_WIDTH  number of frames echoed.
- drop_frame_cnt  out  CNT_WIDTH  number of frames discarded.
- err_frame_cnt  out  CNT_WIDTH  number of frames with a tkeep error.
- busy  out  1  high when mid-frame (state not IDLE) or any buffered beat is present.

Behaviour:
- Clock and reset: one clock, udp_clk. udp_reset is asynchronous and active-high.
- Reset values: every output register is 0 (m_axis_* data/valid, all counters, busy, state = IDLE). s_axis_tready is combinational and reads 1 once reset is released.
- Handshakes:
  - A beat transfers when tvalid && tready at a rising edge. Standard AXIS rules apply.
  - m_axis_* hold stable while m_axis_tvalid=1 and m_axis_tready=0.
- Buffering:
  - One output register plus one skid register (2 beats total).
  - s_axis_tready = !skid_valid in IDLE/FWD, and 1 in DISCARD.
  - Forward latency is 1 cycle (input accepted at edge N appears on m_axis after edge N).
  - With m_axis_tready held at 1, throughput is 1 beat per cycle with no bubbles.
- State machine:
  - IDLE: on an accepted beat, sample echo_enable.
    - enable=1: forward the beat with MAC swap. If tlast=1, stay in IDLE; else go to FWD.
    - enable=0: drop the beat. If tlast=1, stay in IDLE; else go to DISCARD.
  - FWD: forward each accepted beat unmodified. Go to IDLE after the tlast beat.
  - DISCARD: accept and drop every beat. Go to IDLE after the tlast beat.
  - echo_enable changes mid-frame have no effect until the next frame start.
- MAC swap (first beat of an echoed frame only):
  - Output bytes 0..5 = input bytes 6..11.
  - Output bytes 6..11 = input bytes 0..5.
  - All other bytes, tkeep, tuser and tlast pass unchanged.
- tkeep check (per frame):
  - Error on a non-last beat if its tkeep is not all-ones.
  - Error on a last beat if its tkeep is zero, or is not contiguous from bit 0 (i.e. not 2^n-1).
  - The error flag is sticky within the frame and cleared at frame end.
  - Erroneous frames are still echoed or dropped as normal.
- Counters (wrap modulo 2^CNT_WIDTH):
  - Each updates on the cycle the tlast beat is accepted on s_axis.
  - echo_frame_cnt: +1 for frames echoed (FWD, or IDLE with enable=1).
  - drop_frame_cnt: +1 for frames discarded.
  - err_frame_cnt: +1 if the frame's error flag, including the current beat, is set.
  - clear_cnt has priority: if asserted in the same cycle as an increment, the result is 0.
- Reset mid-frame: buffers are flushed, state returns to IDLE and counters go to 0. Remaining beats of the interrupted frame are treated as a new frame.

Decomposition:
- Shared package holds:
  - AXIS beat struct (data/keep/last/user).
  - Constants MAC_ADDR_BYTES=6, ETH_DST_OFFSET=0, ETH_SRC_OFFSET=6.
  - Echo FSM state enum.
  - Function keep_is_contiguous().
- One natural sub-module: axis_skid_buffer (2-entry register slice). Reusable for the cross-die pipelining elsewhere.

Test Plan:
- Reset, then a 1-beat frame: dst=0x112233445566, src=0xAABBCCDDEEFF, tkeep=0x0000_0000_0000_FFFF, tlast=1, enable=1 -> next cycle m_axis shows dst=0xAABBCCDDEEFF, src=0x112233445566, same tkeep; echo_frame_cnt=1.
- Three back-to-back 4-beat frames, m_axis_tready=1 -> 12 output beats on consecutive cycles; only beats 0, 4 and 8 are swapped; echo_frame_cnt=3; s_axis_tready never 0.
- Same traffic with m_axis_tready toggling 1,0,0,1 -> no beat lost or duplicated; output stable while stalled; s_axis_tready drops after 2 buffered beats.
- enable=0 at the first beat of a 5-beat frame, raised to 1 at beat 2 -> whole frame dropped, no m_axis_tvalid, drop_frame_cnt=1; the next frame is echoed.
- Frame with middle-beat tkeep=0xFFFF_FFFF_FFFF_FFFE, then a frame with last-beat tkeep=0x0F0F -> both echoed; err_frame_cnt=2. clear_cnt asserted together with a third tlast -> all counters read 0.
- Assert udp_reset mid-frame during the 3rd of 6 beats -> outputs 0 immediately (asynchronously); after release the remaining beats are processed as a new frame starting in IDLE, with a swap on the first beat.
